// File: rtl/lsu_ctrl_pkg.sv
// Shared types and constants for the data-memory load/store sequencer.
// Holds the RV32I load/store width codes and the sequencer state encoding.
package lsu_ctrl_pkg;

    localparam int XLEN = 32;

    // RV32I funct3 width codes for LOAD and STORE opcodes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory req/ack port: the sequencer is the master, the memory the slave.
// Write-side fields are only meaningful while dmem_req is high.
interface lsu_ctrl_if;
    import lsu_ctrl_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/lsu_ctrl_align.sv
// Combinational lane logic: byte enables, store-data replication, fault
// classification and load-data extraction with sign/zero extension.
module lsu_ctrl_align
    import lsu_ctrl_pkg::*;
(
    input  logic            is_load,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic            misaligned,
    output logic            illegal,
    output logic [XLEN-1:0] ld_data
);

    logic [1:0]  size;
    logic [7:0]  rd_lane [4];
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        load_f3_ok;
    logic        store_f3_ok;

    assign size = funct3[1:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            // Byte ops repeat byte 0, half ops repeat the low half, words pass through
            assign wdata[8*gi +: 8] = (size == 2'b00) ? st_data[7:0] :
                                      (size == 2'b01) ? st_data[8*(gi%2) +: 8] :
                                                        st_data[8*gi +: 8];
            assign rd_lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        be = 4'b1111;
        case (size)
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
    end

    assign load_f3_ok  = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    assign store_f3_ok = funct3 inside {F3_SB, F3_SH, F3_SW};

    assign illegal = (is_load & is_store) |
                     (is_load & ~load_f3_ok) |
                     (is_store & ~store_f3_ok);

    // Alignment is only meaningful once the width code itself is legal
    assign misaligned = ~illegal &
                        (((size == 2'b01) & addr_lo[0]) |
                         ((size == 2'b10) & (addr_lo != 2'b00)));

    assign rd_byte = rd_lane[addr_lo];
    assign rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ld_data = rdata;
        case (funct3)
            F3_LB:   ld_data = {{24{rd_byte[7]}}, rd_byte};
            F3_LH:   ld_data = {{16{rd_half[15]}}, rd_half};
            F3_LBU:  ld_data = {24'd0, rd_byte};
            F3_LHU:  ld_data = {16'd0, rd_half};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns a decoded memory op into one req/ack access,
// stalls the pipeline until it completes, and reports faults as pulses.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_load,
    input  logic             ex_store,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_addr,
    input  logic [XLEN-1:0]  ex_wdata,
    output logic             stall,
    output logic             ld_valid,
    output logic [XLEN-1:0]  ld_data,
    output logic             misalign_err,
    output logic             bus_err,
    lsu_ctrl_if.master       dmem
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    lsu_state_t      state_reg;
    logic [7:0]      cnt_reg;
    logic            req_reg;
    logic            we_reg;
    logic [XLEN-1:0] addr_reg;
    logic [3:0]      be_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [2:0]      f3_reg;
    logic [1:0]      alo_reg;
    logic            ld_valid_reg;
    logic [XLEN-1:0] ld_data_reg;
    logic            misalign_reg;
    logic            bus_err_reg;

    logic            start;
    logic            in_wait;
    logic [2:0]      align_f3;
    logic [1:0]      align_alo;
    logic [3:0]      align_be;
    logic [XLEN-1:0] align_wdata;
    logic            align_misaligned;
    logic            align_illegal;
    logic [XLEN-1:0] align_ld_data;

    assign in_wait = (state_reg == WAIT);
    assign start   = (state_reg == IDLE) & ex_valid & (ex_load | ex_store);
    assign stall   = start | in_wait;

    // One lane unit serves both phases: classify ex_* in IDLE, extend rdata in WAIT
    assign align_f3  = in_wait ? f3_reg  : ex_funct3;
    assign align_alo = in_wait ? alo_reg : ex_addr[1:0];

    lsu_ctrl_align u_align (
        .is_load    (ex_load),
        .is_store   (ex_store),
        .funct3     (align_f3),
        .addr_lo    (align_alo),
        .st_data    (ex_wdata),
        .rdata      (dmem.dmem_rdata),
        .be         (align_be),
        .wdata      (align_wdata),
        .misaligned (align_misaligned),
        .illegal    (align_illegal),
        .ld_data    (align_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            req_reg      <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            be_reg       <= 4'd0;
            wdata_reg    <= '0;
            f3_reg       <= 3'd0;
            alo_reg      <= 2'd0;
            ld_valid_reg <= 1'b0;
            ld_data_reg  <= '0;
            misalign_reg <= 1'b0;
            bus_err_reg  <= 1'b0;
        end else begin
            ld_valid_reg <= 1'b0;
            ld_data_reg  <= '0;
            misalign_reg <= 1'b0;
            bus_err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (align_illegal) begin
                            bus_err_reg <= 1'b1;
                            state_reg   <= RESP;
                        end else if (align_misaligned) begin
                            misalign_reg <= 1'b1;
                            state_reg    <= RESP;
                        end else begin
                            state_reg <= WAIT;
                            req_reg   <= 1'b1;
                            we_reg    <= ex_store;
                            addr_reg  <= {ex_addr[XLEN-1:2], 2'b00};
                            be_reg    <= align_be;
                            wdata_reg <= align_wdata;
                            f3_reg    <= ex_funct3;
                            alo_reg   <= ex_addr[1:0];
                            cnt_reg   <= 8'd0;
                        end
                    end
                end
                WAIT: begin
                    // An ack on the final allowed cycle still counts as success
                    if (dmem.dmem_ack) begin
                        req_reg   <= 1'b0;
                        cnt_reg   <= 8'd0;
                        state_reg <= RESP;
                        if (!we_reg) begin
                            ld_valid_reg <= 1'b1;
                            ld_data_reg  <= align_ld_data;
                        end
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        req_reg     <= 1'b0;
                        cnt_reg     <= 8'd0;
                        bus_err_reg <= 1'b1;
                        state_reg   <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ld_valid     = ld_valid_reg;
    assign ld_data      = ld_data_reg;
    assign misalign_err = misalign_reg;
    assign bus_err      = bus_err_reg;

    assign dmem.dmem_req   = req_reg;
    assign dmem.dmem_we    = we_reg;
    assign dmem.dmem_addr  = addr_reg;
    assign dmem.dmem_be    = be_reg;
    assign dmem.dmem_wdata = wdata_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed plus randomized bench for lsu_ctrl against an arithmetic model of
// lane selection, fault classification, extension and timing.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_load = 1'b0;
    logic        ex_store = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_addr = 32'd0;
    logic [31:0] ex_wdata = 32'd0;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        misalign_err;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_ctrl_if dmem ();

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_load      (ex_load),
        .ex_store     (ex_store),
        .ex_funct3    (ex_funct3),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .stall        (stall),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .dmem         (dmem.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_ldv"}, ld_valid, 0);
        chk({tag, "_ldd"}, ld_data, 0);
        chk({tag, "_mis"}, misalign_err, 0);
        chk({tag, "_berr"}, bus_err, 0);
        chk({tag, "_req"}, dmem.dmem_req, 0);
        chk({tag, "_we"}, dmem.dmem_we, 0);
        chk({tag, "_addr"}, dmem.dmem_addr, 0);
        chk({tag, "_be"}, {28'd0, dmem.dmem_be}, 0);
        chk({tag, "_wd"}, dmem.dmem_wdata, 0);
    endtask

    // One full op from start to the idle cycle after RESP; ack_k outside 1..TO means never ack
    task automatic do_op(input string name, input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input int ack_k,
                         input logic [31:0] rd, output logic [31:0] got_ld);
        bit          ill, mis, tmo;
        int          sz, lo, n_wait;
        logic [31:0] mask, val, exp_wd;
        logic [3:0]  exp_be;

        ill = (ld && st) || (ld && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) ||
              (st && f3 > 2);
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        lo  = int'(addr % 4);
        mis = !ill && ((addr % sz) != 0);
        tmo = (ack_k < 1) || (ack_k > TO);
        n_wait = tmo ? TO : ack_k;
        exp_be = 4'(((1 << sz) - 1) << lo);
        if (sz == 1)      exp_wd = (wd & 32'hFF) * 32'h01010101;
        else if (sz == 2) exp_wd = (wd & 32'hFFFF) * 32'h00010001;
        else              exp_wd = wd;
        mask = (sz == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * sz)) - 1);
        val  = (rd >> (8 * lo)) & mask;
        if (f3[2] == 1'b0 && sz < 4 && val[8*sz-1]) val = val | ~mask;

        $display("op %s ld=%0b st=%0b f3=%0d addr=%h wd=%h ack_k=%0d rd=%h", name, ld, st, f3,
                 addr, wd, ack_k, rd);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
        ex_addr = addr; ex_wdata = wd;
        @(negedge clk);
        chk({name, "_start_stall"}, stall, 1);
        chk({name, "_start_req"}, dmem.dmem_req, 0);
        @(posedge clk); #1;

        if (ill || mis) begin
            @(negedge clk);
            chk({name, "_f_req"}, dmem.dmem_req, 0);
            chk({name, "_f_mis"}, misalign_err, 32'(mis));
            chk({name, "_f_berr"}, bus_err, 32'(ill));
            chk({name, "_f_ldv"}, ld_valid, 0);
            chk({name, "_f_stall"}, stall, 0);
        end else begin
            for (int c = 1; c <= n_wait; c++) begin
                if (!tmo && c == ack_k) begin
                    dmem.dmem_ack = 1'b1;
                    dmem.dmem_rdata = rd;
                end
                @(negedge clk);
                chk({name, "_w_req"}, dmem.dmem_req, 1);
                chk({name, "_w_we"}, dmem.dmem_we, 32'(st));
                chk({name, "_w_addr"}, dmem.dmem_addr, addr & 32'hFFFFFFFC);
                chk({name, "_w_be"}, {28'd0, dmem.dmem_be}, {28'd0, exp_be});
                if (st) chk({name, "_w_wd"}, dmem.dmem_wdata, exp_wd);
                chk({name, "_w_stall"}, stall, 1);
                chk({name, "_w_pulse"}, {30'd0, bus_err, ld_valid}, 0);
                @(posedge clk); #1;
                dmem.dmem_ack = 1'b0;
                dmem.dmem_rdata = $urandom;
            end
            @(negedge clk);
            chk({name, "_r_req"}, dmem.dmem_req, 0);
            chk({name, "_r_stall"}, stall, 0);
            chk({name, "_r_ldv"}, ld_valid, 32'(ld && !tmo));
            chk({name, "_r_berr"}, bus_err, 32'(tmo));
            chk({name, "_r_mis"}, misalign_err, 0);
            if (ld && !tmo) chk({name, "_r_ldd"}, ld_data, val);
        end
        got_ld = ld_data;

        // Idle cycle with a stray ack that must be ignored
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        dmem.dmem_ack = 1'($urandom % 2);
        @(negedge clk);
        chk({name, "_i_stall"}, stall, 0);
        chk({name, "_i_req"}, dmem.dmem_req, 0);
        @(posedge clk); #1;
        dmem.dmem_ack = 1'b0;
        @(negedge clk);
        chk({name, "_i_pulse"}, {29'd0, misalign_err, bus_err, ld_valid}, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] got;
        logic [2:0]  legal_ld [5];
        bit          rl, rs;
        logic [2:0]  rf;

        legal_ld[0] = 3'd0; legal_ld[1] = 3'd1; legal_ld[2] = 3'd2;
        legal_ld[3] = 3'd4; legal_ld[4] = 3'd5;
        dmem.dmem_ack = 1'b0;
        dmem.dmem_rdata = 32'd0;

        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("sw", 0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 2, 32'h0, got);
        do_op("lb", 1, 0, 3'd0, 32'h203, 32'h0, 1, 32'h80AA5511, got);
        chk("lb_const", got, 32'hFFFFFF80);
        do_op("lbu", 1, 0, 3'd4, 32'h203, 32'h0, 1, 32'h80AA5511, got);
        chk("lbu_const", got, 32'h00000080);
        do_op("sh", 0, 1, 3'd1, 32'h402, 32'h1234ABCD, 1, 32'h0, got);
        do_op("lh", 1, 0, 3'd1, 32'h402, 32'h0, 2, 32'h80017777, got);
        chk("lh_const", got, 32'hFFFF8001);
        do_op("lw_mis", 1, 0, 3'd2, 32'h101, 32'h0, 1, 32'h0, got);
        do_op("ld_f3_3", 1, 0, 3'd3, 32'h100, 32'h0, 1, 32'h0, got);
        do_op("ldst", 1, 1, 3'd2, 32'h100, 32'h0, 1, 32'h0, got);
        do_op("ld_tmo", 1, 0, 3'd2, 32'h300, 32'h0, 0, 32'h0, got);
        do_op("ld_ack_last", 1, 0, 3'd2, 32'h300, 32'h0, TO, 32'hCAFEF00D, got);
        chk("lw_last_const", got, 32'hCAFEF00D);

        // Reset in the middle of a WAIT, then a late ack that must be ignored
        $display("op reset_mid_wait");
        ex_valid = 1'b1; ex_store = 1'b1; ex_funct3 = 3'd2; ex_addr = 32'h500; ex_wdata = 32'h11223344;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; ex_valid = 1'b0; ex_store = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        dmem.dmem_ack = 1'b1;
        dmem.dmem_rdata = 32'h55555555;
        @(negedge clk);
        chk("late_ack_req", dmem.dmem_req, 0);
        @(posedge clk); #1;
        dmem.dmem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_pulse", {29'd0, misalign_err, bus_err, ld_valid}, 0);
        chk("late_ack_stall", stall, 0);
        @(posedge clk); #1;
        do_op("sw_after_rst", 0, 1, 3'd2, 32'h504, 32'h0BADF00D, 1, 32'h0, got);

        for (int i = 0; i < 60; i++) begin
            rl = 1'($urandom % 2);
            rs = !rl;
            if ($urandom % 16 == 0) begin rl = 1'b1; rs = 1'b1; end
            if ($urandom % 4 == 0) rf = 3'($urandom % 8);
            else if (rl)           rf = legal_ld[$urandom % 5];
            else                   rf = 3'($urandom % 3);
            do_op($sformatf("rnd%0d", i), rl, rs, rf, $urandom, $urandom,
                  int'($urandom_range(0, 6)), $urandom, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
